key_encoder: RTL and testbench
==============================

// Module: key_encoder
// PURPOSE
//  Reverse path of the UART keypad link: turns local key events (board buttons
//  mapped to w/s/a/d/space/enter) into ASCII bytes for the UART transmitter.
//  Rising edges are rate-limited per key, then queued in a small FIFO.
//  Bytes are presented on a valid/ready byte interface feeding the UART TX.
// PARAMETERS
//  FIFO_DEPTH       4       byte FIFO entries; power of two, >= 2
//  COOLDOWN_CYCLES  500000  per-key lockout after an accepted edge (5 ms @ 100 MHz); 0 disables
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high
//  up_key     in   1  level; rising edge -> 'w' 8'h77
//  down_key   in   1  level; rising edge -> 's' 8'h73
//  left_key   in   1  level; rising edge -> 'a' 8'h61
//  right_key  in   1  level; rising edge -> 'd' 8'h64
//  space_key  in   1  level; rising edge -> ' ' 8'h20
//  enter_key  in   1  level; rising edge -> CR 8'h0D
//  tx_data    out  8  byte at FIFO head
//  tx_valid   out  1  tx_data valid
//  tx_ready   in   1  UART TX accepts byte when tx_valid & tx_ready
//  drop       out  1  1-cycle pulse: edge lost because same key already pending
//  busy       out  1  any pending event or FIFO non-empty
// BEHAVIOUR
//  - All logic on posedge clk. Reset is synchronous and active-high.
//  - Reset values: tx_valid=0, tx_data=8'h00, drop=0, busy=0.
//    Reset also clears FIFO, pointers, pending bits and cooldowns.
//    Previous-key registers are set to all 1s, so keys held through reset
//    raise no event.
//  - Edge detect: edge = key & ~key_q, where key_q is the prior-cycle sample.
//  - Edge while that key's cooldown != 0: ignored silently.
//    Otherwise it sets the key's pending bit and loads cooldown = COOLDOWN_CYCLES.
//    If the pending bit is already set: the bit stays set, drop=1 for one cycle,
//    and the cooldown still reloads.
//  - Cooldowns decrement by 1 per cycle while nonzero and saturate at 0.
//  - Arbiter: each cycle, pushes at most one pending key (highest priority) into
//    the FIFO if there is space. The pushed key's pending bit clears.
//    Priority: ENTER > SPACE > W > S > A > D.
//  - FIFO: first-word-fall-through. tx_valid = !empty; tx_data = head entry.
//    Pop on tx_valid & tx_ready. Push and pop in the same cycle are allowed;
//    when full, a push succeeds only if a pop happens in the same cycle.
//    Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//    full = MSBs differ and lower bits equal.
//  - Latency (idle, FIFO empty): edge in cycle N -> pending set end of N
//    -> pushed end of N+1 -> tx_valid=1 with byte in cycle N+2.
//  - Under backpressure (tx_valid=1, tx_ready=0), tx_data holds stable.
//  - FIFO full: events wait in pending; nothing is lost except same-key re-edges.
//  - tx_data when empty: last popped value (don't-care; bench checks only while valid).
//  - busy = |pending | !empty.
// CONFIGURATION
//  KEY_ENCODER_CRLF_EN defined:
//   - ENTER pushes two bytes atomically, 8'h0D then 8'h0A.
//   - ENTER is granted only when >= 2 entries are free (counting a same-cycle pop).
//     Otherwise ENTER stays pending and lower-priority keys are NOT granted
//     that cycle, which preserves ordering.
//  KEY_ENCODER_CRLF_EN undefined: ENTER pushes 8'h0D only.
// TESTING
//  1. COOLDOWN=0, tx_ready=1, up_key pulse at cycle N -> tx_valid=1, tx_data=8'h77
//     in cycle N+2 only; busy falls after the pop.
//  2. left, right and enter rise in the same cycle, tx_ready=1 -> bytes 8'h0D, 8'h61,
//     8'h64 on consecutive cycles (CRLF_EN: 8'h0D, 8'h0A, 8'h61, 8'h64).
//  3. tx_ready=0; w, s, a, d, space pulsed on separate cycles -> FIFO holds
//     77,73,61,64 and space stays pending. Re-pulse space -> drop=1 for one cycle.
//     Release tx_ready -> 77,73,61,64,20 in order, with 20 sent once.
//  4. COOLDOWN_CYCLES=100: w pulses at t=0 and t=10 -> one 8'h77;
//     a w pulse at t=110 -> a second 8'h77.
//  5. Backpressure: tx_ready toggled 0/1 randomly over 20 events -> tx_data constant
//     while valid & !ready; output sequence equals the input event order.
//  6. reset asserted for 1 cycle with 3 bytes queued and enter_key held high ->
//     tx_valid=0 and busy=0 the next cycle; no byte emitted after reset until enter
//     is released and pressed again.

Source files
------------

// File: rtl/key_encoder.sv
// key_encoder: turns local key presses into ASCII bytes for the UART TX.
// Each key gets edge detection and a per-key cooldown. Accepted edges set a pending
// bit, and a fixed-priority arbiter moves pending keys into a first-word-fall-through
// byte FIFO.
// Optional feature: define KEY_ENCODER_CRLF_EN so that ENTER emits CR then LF atomically.
module key_encoder #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned COOLDOWN_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_key,
  input  logic       down_key,
  input  logic       left_key,
  input  logic       right_key,
  input  logic       space_key,
  input  logic       enter_key,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       drop,
  output logic       busy
);

  localparam int          NumKeys = 6;
  localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW    = AddrW + 1;
  localparam int unsigned CntW    = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

  // Key vector index doubles as priority rank: 0 (ENTER) is highest.
  localparam logic [2:0] KeyEnter = 3'd0;

  logic [NumKeys-1:0] key_vec, key_q, key_edge, cool_zero, accept;
  logic [NumKeys-1:0] pending_q, pending_d, grant;
  logic [CntW-1:0]    cool_q [NumKeys];
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wptr_q, wptr_d, rptr_q;
  logic [AddrW-1:0]   widx, widx_next;
  logic               empty, full, pop, push, push_two, room1, drop_q, drop_d;
  logic               sel_found;
  logic [2:0]         sel_idx;
  logic [7:0]         push_byte;

  assign key_vec = {right_key, left_key, down_key, up_key, space_key, enter_key};

  // FIFO status and output view
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign tx_valid  = !empty;
  assign tx_data   = mem_q[rptr_q[AddrW-1:0]];
  assign pop       = tx_valid & tx_ready;
  assign room1     = !full || pop;
  assign widx      = wptr_q[AddrW-1:0];
  assign widx_next = widx + AddrW'(1);
  assign busy      = (|pending_q) | !empty;
  assign drop      = drop_q;

`ifdef KEY_ENCODER_CRLF_EN
  logic [PtrW-1:0] count;
  logic [PtrW:0]   avail;
  assign count = wptr_q - rptr_q;
  // Free slots, counting a slot that a same-cycle pop releases
  assign avail = (PtrW + 1)'(FIFO_DEPTH) - {1'b0, count} + {{PtrW{1'b0}}, pop};
`endif

  // Edge detection, cooldown gating and pending-bit bookkeeping
  always_comb begin
    key_edge = key_vec & ~key_q;
    for (int i = 0; i < NumKeys; i++) begin
      cool_zero[i] = (cool_q[i] == '0);
    end
    accept    = key_edge & cool_zero;
    // A key being pushed this cycle frees its pending bit, so a re-edge is kept
    pending_d = (pending_q & ~grant) | accept;
    drop_d    = |(accept & pending_q & ~grant);
  end

  // Fixed-priority arbiter: at most one key per cycle into the FIFO
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    for (int i = NumKeys - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
    grant    = '0;
    push     = 1'b0;
    push_two = 1'b0;
`ifdef KEY_ENCODER_CRLF_EN
    if (sel_found) begin
      if (sel_idx == KeyEnter) begin
        // ENTER waits for two free slots; lower keys are held back to keep ordering
        if (avail >= (PtrW + 1)'(2)) begin
          grant[sel_idx] = 1'b1;
          push           = 1'b1;
          push_two       = 1'b1;
        end
      end else if (room1) begin
        grant[sel_idx] = 1'b1;
        push           = 1'b1;
      end
    end
`else
    if (sel_found && room1) begin
      grant[sel_idx] = 1'b1;
      push           = 1'b1;
    end
`endif
    wptr_d = wptr_q + PtrW'(push) + PtrW'(push_two);
  end

  // Byte code for the granted key
  always_comb begin
    case (sel_idx)
      3'd0:    push_byte = 8'h0D;
      3'd1:    push_byte = 8'h20;
      3'd2:    push_byte = 8'h77;
      3'd3:    push_byte = 8'h73;
      3'd4:    push_byte = 8'h61;
      3'd5:    push_byte = 8'h64;
      default: push_byte = 8'h00;
    endcase
  end

  // Key sampling, pending bits and drop pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q     <= '1;  // keys held through reset raise no event
      pending_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      key_q     <= key_vec;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  // Per-key cooldown counters, saturating at zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumKeys; i++) begin
      if (reset) begin
        cool_q[i] <= '0;
      end else if (accept[i]) begin
        cool_q[i] <= CntW'(COOLDOWN_CYCLES);
      end else if (!cool_zero[i]) begin
        cool_q[i] <= cool_q[i] - CntW'(1);
      end
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        mem_q[widx] <= push_byte;
      end
      if (push_two) begin
        mem_q[widx_next] <= 8'h0A;
      end
      wptr_q <= wptr_d;
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder: scoreboard of expected bytes, popped on each TX handshake.
module tb_key_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] keys = '0;  // {enter, space, right, left, down, up}
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid, drop, busy;

  // Second instance with a short cooldown
  logic       cd_up = 1'b0;
  logic [7:0] cd_data;
  logic       cd_valid, cd_drop, cd_busy;

  localparam logic [5:0] MaskUp    = 6'd1;
  localparam logic [5:0] MaskDown  = 6'd2;
  localparam logic [5:0] MaskLeft  = 6'd4;
  localparam logic [5:0] MaskRight = 6'd8;
  localparam logic [5:0] MaskSpace = 6'd16;
  localparam logic [5:0] MaskEnter = 6'd32;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;
  logic       t5_done;

  key_encoder #(.FIFO_DEPTH(4), .COOLDOWN_CYCLES(0)) dut (
    .clk(clk), .reset(reset),
    .up_key(keys[0]), .down_key(keys[1]), .left_key(keys[2]), .right_key(keys[3]),
    .space_key(keys[4]), .enter_key(keys[5]),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .drop(drop), .busy(busy)
  );

  key_encoder #(.FIFO_DEPTH(4), .COOLDOWN_CYCLES(100)) dut_cd (
    .clk(clk), .reset(reset),
    .up_key(cd_up), .down_key(1'b0), .left_key(1'b0), .right_key(1'b0),
    .space_key(1'b0), .enter_key(1'b0),
    .tx_data(cd_data), .tx_valid(cd_valid), .tx_ready(1'b1),
    .drop(cd_drop), .busy(cd_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] key_byte(input int idx);
    case (idx)
      0:       return 8'h77;
      1:       return 8'h73;
      2:       return 8'h61;
      3:       return 8'h64;
      4:       return 8'h20;
      default: return 8'h0D;
    endcase
  endfunction

  task automatic push_exp(input int idx);
    exp_q.push_back(key_byte(idx));
`ifdef KEY_ENCODER_CRLF_EN
    if (idx == 5) exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic pulse(input logic [5:0] m);
    @(posedge clk); #1 keys = m;
    @(posedge clk); #1 keys = '0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
  endtask

  // Scoreboard monitor and backpressure stability check
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_unexpected: got byte %h, expected no output", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (tx_data !== mon_exp)
            $display("FAIL out_byte: got %h, expected %h", tx_data, mon_exp);
          else n_pass++;
        end
      end
      if (prev_valid && !prev_ready && !prev_rst) begin
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data)
          $display("FAIL hold: got valid=%b data=%h, expected valid=1 data=%h",
                   tx_valid, tx_data, prev_data);
        else n_pass++;
      end
    end
    prev_valid = tx_valid;
    prev_ready = tx_ready;
    prev_data  = tx_data;
    prev_rst   = reset;
  end

  task automatic test_reset;
    reset = 1'b1; keys = '0; tx_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL rst_valid: got %b, expected 0", tx_valid);
    else n_pass++;
    n_checks++;
    if (tx_data !== 8'h00) $display("FAIL rst_data: got %h, expected 00", tx_data);
    else n_pass++;
    n_checks++;
    if (drop !== 1'b0) $display("FAIL rst_drop: got %b, expected 0", drop);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_single;
    bit ok;
    tx_ready = 1'b1;
    @(posedge clk); #1 keys = MaskUp;
    push_exp(0);
    @(negedge clk);  // cycle N
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL single_n0: got valid=%b, expected 0", tx_valid);
    else n_pass++;
    @(posedge clk); #1 keys = '0;
    @(negedge clk);  // N+1
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_n1: got valid=%b busy=%b, expected 0/1", tx_valid, busy);
    else n_pass++;
    @(negedge clk);  // N+2
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77)
      $display("FAIL single_n2: got valid=%b data=%h, expected 1/77", tx_valid, tx_data);
    else n_pass++;
    @(negedge clk);  // N+3
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_n3: got valid=%b busy=%b, expected 0/0", tx_valid, busy);
    else n_pass++;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL single_drain: got %0d left, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    bit ok, found;
    int run, nb;
`ifdef KEY_ENCODER_CRLF_EN
    nb = 4;
`else
    nb = 3;
`endif
    tx_ready = 1'b1;
    pulse(MaskLeft | MaskRight | MaskEnter);
    push_exp(5); push_exp(2); push_exp(3);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (tx_valid) found = 1'b1;
    end
    run = 0;
    while (tx_valid && run < 10) begin
      run++;
      @(negedge clk);
    end
    n_checks++;
    if (run != nb) $display("FAIL simul_run: got %0d consecutive bytes, expected %0d", run, nb);
    else n_pass++;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL simul_drain: got %0d left, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_full_pending;
    bit ok;
    int drops;
    tx_ready = 1'b0;
    pulse(MaskUp);    push_exp(0);
    pulse(MaskDown);  push_exp(1);
    pulse(MaskLeft);  push_exp(2);
    pulse(MaskRight); push_exp(3);
    pulse(MaskSpace); push_exp(4);
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77 || busy !== 1'b1)
      $display("FAIL full_head: got valid=%b data=%h busy=%b, expected 1/77/1",
               tx_valid, tx_data, busy);
    else n_pass++;
    n_checks++;
    if (drop !== 1'b0) $display("FAIL full_nodrop: got %b, expected 0", drop);
    else n_pass++;
    drops = 0;
    @(posedge clk); #1 keys = MaskSpace;
    @(negedge clk); drops += int'(drop);
    @(posedge clk); #1 keys = '0;
    repeat (4) begin
      @(negedge clk); drops += int'(drop);
    end
    n_checks++;
    if (drops != 1) $display("FAIL full_drop: got %0d drop cycles, expected 1", drops);
    else n_pass++;
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL full_drain: got %0d left, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_cooldown;
    int cnt, c105, bad;
    cnt = 0; c105 = -1; bad = 0;
    for (int t = 0; t < 140; t++) begin
      @(posedge clk); #1 cd_up = (t == 0 || t == 10 || t == 110);
      @(negedge clk);
      if (cd_valid) begin
        cnt++;
        if (cd_data !== 8'h77) bad++;
      end
      if (t == 105) c105 = cnt;
    end
    cd_up = 1'b0;
    n_checks++;
    if (c105 != 1) $display("FAIL cool_first: got %0d bytes by t=105, expected 1", c105);
    else n_pass++;
    n_checks++;
    if (cnt != 2) $display("FAIL cool_total: got %0d bytes, expected 2", cnt);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL cool_data: got %0d non-77 bytes, expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int idx, tmo;
    t5_done = 1'b0;
    tmo = 0;
    fork
      begin
        while (!t5_done) begin
          @(posedge clk); #1 tx_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int ev = 0; ev < 20; ev++) begin
          for (int w = 0; w < 200 && exp_q.size() > 1; w++) @(negedge clk);
          if (exp_q.size() > 1) tmo++;
          idx = int'($urandom_range(0, 5));
          pulse(6'(1) << idx);
          push_exp(idx);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        t5_done = 1'b1;
      end
    join
    @(posedge clk); #1 tx_ready = 1'b1;
    n_checks++;
    if (tmo != 0) $display("FAIL bp_wait: got %0d timeouts, expected 0", tmo);
    else n_pass++;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL bp_drain: got %0d left, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midstream;
    bit ok;
    int seen;
    tx_ready = 1'b0;
    pulse(MaskUp);   push_exp(0);
    pulse(MaskDown); push_exp(1);
    pulse(MaskLeft); push_exp(2);
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77)
      $display("FAIL mid_queued: got valid=%b data=%h, expected 1/77", tx_valid, tx_data);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b1; keys = MaskEnter; exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_rst: got valid=%b busy=%b, expected 0/0", tx_valid, busy);
    else n_pass++;
    tx_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL mid_held: got %0d valid cycles, expected 0", seen);
    else n_pass++;
    @(posedge clk); #1 keys = '0;
    repeat (2) @(posedge clk);
    pulse(MaskEnter); push_exp(5);
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL mid_drain: got %0d left, expected 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_full_pending();
    test_cooldown();
    test_back_to_back();
    test_reset_midstream();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
